// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter.
// One output register stage; output beats tagged with source port.
module axis_pkt_rr_arbiter #(
  parameter int PORTS           = 4,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int ID_WIDTH        = $clog2(PORTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PORTS*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS*AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [PORTS-1:0]                   s_axis_tvalid,
  output logic [PORTS-1:0]                   s_axis_tready,
  input  logic [PORTS-1:0]                   s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [ID_WIDTH-1:0]                m_axis_tid
);

  typedef enum logic {
    IDLE,
    PASS
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] sel;
  logic                found;
  logic                in_beat;
  logic                in_last;
  logic                out_beat;
  logic [PORTS-1:0]    ready;

  // Round-robin search starting just after the previous winner
  always_comb begin : rr_search
    int idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= PORTS; i++) begin
      idx = (int'(last_grant) + i) % PORTS;
      if (!found && s_axis_tvalid[idx]) begin
        found = 1'b1;
        sel   = ID_WIDTH'(idx);
      end
    end
  end

  // Next state and per-port ready; only the granted port sees ready
  always_comb begin
    state_nx = state;
    ready    = '0;
    in_beat  = 1'b0;
    in_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) state_nx = PASS;
      end
      PASS: begin
        ready[grant] = !m_axis_tvalid | m_axis_tready;
        in_beat = s_axis_tvalid[grant] & ready[grant];
        in_last = in_beat & s_axis_tlast[grant];
        if (in_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign s_axis_tready = ready;
  assign out_beat      = m_axis_tvalid & m_axis_tready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Grant capture at arbitration, winner memory at packet end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= ID_WIDTH'(PORTS - 1);
    end else begin
      if (state == IDLE && found) grant <= sel;
      if (in_last) last_grant <= grant;
    end
  end

  // Output register control: reload on input beat, clear on drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else if (in_beat) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s_axis_tlast[grant];
      m_axis_tid    <= grant;
    end else if (out_beat) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Output payload; no reset needed since valid qualifies it
  always_ff @(posedge clk) begin
    if (in_beat) begin
      m_axis_tdata <= s_axis_tdata[grant*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
      m_axis_tkeep <= s_axis_tkeep[grant*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
    end
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Bench for axis_pkt_rr_arbiter: directed + random packets,
// packet-level round-robin model and in-order scoreboard.
module tb_axis_pkt_rr_arbiter;

  localparam int P  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [3:0]    hold;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] tid;
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } out_t;

  logic            clk;
  logic            rst;
  logic [P*DW-1:0] s_tdata;
  logic [P*KW-1:0] s_tkeep;
  logic [P-1:0]    s_tvalid;
  logic [P-1:0]    s_tready;
  logic [P-1:0]    s_tlast;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;

  axis_pkt_rr_arbiter #(
    .PORTS(P),
    .AXIS_DATA_WIDTH(DW),
    .AXIS_KEEP_WIDTH(KW),
    .ID_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid)
  );

  int     nerr;
  int     nchk;
  int     cyc;
  int     rmode;
  int     mlast;
  logic   rtog;
  logic [P-1:0] fire;
  beat_t  dq[P][$];
  beat_t  pend[P][$];
  out_t   expq[$];
  out_t   obsq[$];
  int     obscyc[$];
  logic   stall;
  out_t   held;
  out_t   cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Source drivers and downstream ready, updated just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < P; p++) begin
      beat_t b;
      if (fire[p] && dq[p].size() > 0) dq[p].delete(0);
      s_tvalid[p] = 1'b0;
      if (dq[p].size() > 0) begin
        b = dq[p][0];
        if (b.hold != 0) begin
          b.hold = b.hold - 4'd1;
          dq[p][0] = b;
        end else begin
          s_tvalid[p] = 1'b1;
          s_tdata[p*DW +: DW] = b.data;
          s_tkeep[p*KW +: KW] = b.keep;
          s_tlast[p] = b.last;
        end
      end
    end
    rtog = ~rtog;
    case (rmode)
      1:       m_tready = rtog;
      2:       m_tready = 1'($urandom);
      default: m_tready = 1'b1;
    endcase
  end

  // Output monitor: handshake capture, hold-while-stalled, one-hot ready
  initial forever begin
    @(negedge clk);
    fire = s_tvalid & s_tready;
    cur = {m_tid, m_tlast, m_tkeep, m_tdata};
    if (rst) begin
      stall = 1'b0;
    end else begin
      chk("ready_onehot", 128'($onehot0(s_tready)), 128'(1));
      if (stall) begin
        chk("stall_valid", 128'(m_tvalid), 128'(1));
        chk("stall_hold", 128'(cur), 128'(held));
      end
      if (m_tvalid && m_tready) begin
        obsq.push_back(cur);
        obscyc.push_back(cyc);
        stall = 1'b0;
      end else if (m_tvalid) begin
        stall = 1'b1;
        held = cur;
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic mkpkt(input int p, input int n, input int gap_at,
                       input int gap_len);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.last = (i == n - 1);
      b.hold = (i == gap_at) ? 4'(gap_len) : 4'd0;
      pend[p].push_back(b);
    end
  endtask

  // Hand pending packets to drivers; predict order packet by packet
  task automatic commit();
    beat_t b;
    bit    any;
    int    w;
    out_t  o;
    for (int p = 0; p < P; p++)
      foreach (pend[p][i]) dq[p].push_back(pend[p][i]);
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      w = 0;
      for (int i = 1; i <= P && !any; i++) begin
        if (pend[(mlast + i) % P].size() > 0) begin
          any = 1'b1;
          w = (mlast + i) % P;
        end
      end
      if (any) begin
        do begin
          b = pend[w].pop_front();
          o.tid  = IW'(w);
          o.last = b.last;
          o.keep = b.keep;
          o.data = b.data;
          expq.push_back(o);
        end while (!b.last);
        mlast = w;
      end
    end
  endtask

  task automatic drain(input string tag, input int gap);
    for (int i = 0; i < 2000 && obsq.size() < expq.size(); i++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 128'(obsq.size()), 128'(expq.size()));
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      chk($sformatf("%s_beat%0d", tag, i), 128'(obsq[i]), 128'(expq[i]));
      if (gap != 0 && i > 0)
        chk($sformatf("%s_gap%0d", tag, i),
            128'(obscyc[i] - obscyc[i-1]), 128'(gap));
    end
    expq.delete();
    obsq.delete();
    obscyc.delete();
  endtask

  task automatic clear_all();
    for (int p = 0; p < P; p++) begin
      dq[p].delete();
      pend[p].delete();
    end
    fire = '0;
    expq.delete();
    obsq.delete();
    obscyc.delete();
    mlast = P - 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tp;
    nerr = 0; nchk = 0; cyc = 0; rmode = 0; rtog = 1'b0;
    stall = 1'b0; held = '0; cur = '0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0;
    m_tready = 1'b1;
    rst = 1'b1;
    clear_all();
    repeat (3) @(negedge clk);
    chk("rst_mvalid", 128'(m_tvalid), 128'(0));
    chk("rst_mlast", 128'(m_tlast), 128'(0));
    chk("rst_mtid", 128'(m_tid), 128'(0));
    chk("rst_sready", 128'(s_tready), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1: port 2, 3 beats, back-to-back output
    mkpkt(2, 3, -1, 0);
    commit();
    @(negedge clk);
    chk("t1_idle_ready", 128'(s_tready), 128'(4'b0000));
    @(negedge clk);
    chk("t1_grant_ready", 128'(s_tready), 128'(4'b0100));
    drain("t1", 1);

    // 2: all ports, single-beat packets, rotating grant
    do_reset();
    for (int p = 0; p < P; p++) mkpkt(p, 1, -1, 0);
    mkpkt(0, 1, -1, 0);
    mkpkt(1, 1, -1, 0);
    commit();
    drain("t2", 2);

    // 3: port 0 requests while port 1 holds the grant
    mkpkt(1, 4, -1, 0);
    commit();
    repeat (2) @(negedge clk);
    mkpkt(0, 2, -1, 0);
    commit();
    repeat (2) begin
      @(negedge clk);
      chk("t3_hold_grant", 128'(s_tready), 128'(4'b0010));
    end
    drain("t3", 0);

    // 4: toggling downstream ready on a 5-beat packet
    rmode = 1;
    tp = $urandom_range(0, P - 1);
    mkpkt(tp, 5, -1, 0);
    commit();
    drain("t4", 0);
    rmode = 0;

    // 5: reset in the middle of a packet
    mkpkt(2, 4, -1, 0);
    commit();
    for (int i = 0; i < 50 && dq[2].size() != 3; i++) @(negedge clk);
    chk("t5_sync", 128'(dq[2].size()), 128'(3));
    chk("t5_pre_valid", 128'(m_tvalid), 128'(1));
    #2;
    rst = 1'b1;
    clear_all();
    #1;
    chk("t5_rst_valid", 128'(m_tvalid), 128'(0));
    chk("t5_rst_ready", 128'(s_tready), 128'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mkpkt(3, 2, -1, 0);
    mkpkt(2, 4, -1, 0);
    mkpkt(0, 3, -1, 0);
    commit();
    @(negedge clk);
    chk("t5_idle_ready", 128'(s_tready), 128'(4'b0000));
    @(negedge clk);
    chk("t5_first_grant", 128'(s_tready), 128'(4'b0001));
    drain("t5", 0);

    // 6: granted port stalls its valid while port 0 waits
    mkpkt(3, 5, 2, 3);
    commit();
    repeat (2) @(negedge clk);
    mkpkt(0, 2, -1, 0);
    commit();
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("t6_hold_grant", 128'(s_tready), 128'(4'b1000));
    end
    drain("t6", 0);

    // Random packets on all ports with random downstream ready
    rmode = 2;
    repeat (3) begin
      for (int p = 0; p < P; p++) begin
        int npk;
        npk = $urandom_range(1, 2);
        for (int k = 0; k < npk; k++) begin
          int n;
          n = $urandom_range(1, 4);
          if (n > 1) mkpkt(p, n, $urandom_range(1, n - 1), $urandom_range(0, 2));
          else       mkpkt(p, n, -1, 0);
        end
      end
      commit();
      drain("rnd", 0);
    end
    rmode = 0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
